// File: rtl/fetch_sequencer.sv
// fetch_sequencer: byte-serial instruction fetch. Each instruction is an opcode
// byte plus 0, 1 or 2 operand bytes, handed to the decoder with a ready/done
// handshake.
// Optional feature macro: FETCH_WATCHDOG_EN builds an EXEC-cycle watchdog that
// abandons a stuck instruction and raises a sticky timeout flag.
module fetch_sequencer #(
  parameter int unsigned           REG_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           WDOG_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ack,
  input  logic [REG_WIDTH-1:0]  mem_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [ADDR_WIDTH-1:0] operand,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  halt,
  output logic                  timeout
);

  // The high operand byte fills whatever is left of the address above the low byte.
  localparam int unsigned HiW = ADDR_WIDTH - REG_WIDTH;

  // Opcode field decode needs an 8-bit opcode; the operand must fit in two bytes.
  if (REG_WIDTH != 8 || ADDR_WIDTH <= REG_WIDTH || ADDR_WIDTH > 2 * REG_WIDTH ||
      WDOG_CYCLES < 1) begin : g_param_check
    $error("fetch_sequencer: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetchOp,
    StFetchLo,
    StFetchHi,
    StExec,
    StHalt
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [REG_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   operand_q, operand_d;
  logic                    wdog_expired;

  // Number of operand bytes following an opcode {aaa,bbb,cc}.
  function automatic logic [1:0] op_count(input logic [REG_WIDTH-1:0] op);
    logic [2:0] aaa, bbb;
    logic [1:0] cc;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    if (bbb == 3'b011 || bbb == 3'b111) begin
      op_count = 2'd2;
    end else if (cc == 2'b01) begin
      op_count = (bbb == 3'b110) ? 2'd2 : 2'd1;
    end else if (bbb == 3'b010 || bbb == 3'b110) begin
      op_count = 2'd0;
    end else if (bbb == 3'b000) begin
      if (aaa[2]) begin
        op_count = 2'd1;
      end else if (op == REG_WIDTH'(8'h20)) begin
        op_count = 2'd2;
      end else begin
        op_count = 2'd0;
      end
    end else begin
      op_count = 2'd1;
    end
  endfunction

  // Next-state, pc and latch logic for the fetch/exec sequence.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    unique case (state_q)
      StIdle: begin
        state_d = halt ? StHalt : StFetchOp;
      end
      StFetchOp: begin
        if (mem_ack) begin
          instr_d   = mem_data;
          operand_d = '0;
          pc_d      = pc_q + ADDR_WIDTH'(1);
          state_d   = (op_count(mem_data) != 2'd0) ? StFetchLo : StExec;
        end
      end
      StFetchLo: begin
        if (mem_ack) begin
          operand_d[REG_WIDTH-1:0] = mem_data;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = (op_count(instr_q) == 2'd2) ? StFetchHi : StExec;
        end
      end
      StFetchHi: begin
        if (mem_ack) begin
          operand_d[ADDR_WIDTH-1:REG_WIDTH] = mem_data[HiW-1:0];
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = StExec;
        end
      end
      StExec: begin
        if (instruction_done) begin
          if (jump_valid) begin
            pc_d = jump_addr;
          end
          state_d = halt ? StHalt : StFetchOp;
        end else if (wdog_expired) begin
          // Abandon the instruction and refetch from where pc already points.
          state_d = StFetchOp;
        end
      end
      StHalt: begin
        if (!halt) begin
          state_d = StFetchOp;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state, program counter and latched instruction bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
    end
  end

`ifdef FETCH_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             timeout_q, timeout_d;

  assign wdog_expired = (state_q == StExec) && !instruction_done &&
                        (wdog_cnt_q == WdogW'(WDOG_CYCLES - 1));

  // Count EXEC cycles; any non-EXEC cycle clears the count so it restarts on entry.
  always_comb begin
    wdog_cnt_d = '0;
    timeout_d  = timeout_q | wdog_expired;
    if (state_q == StExec && !instruction_done && !wdog_expired) begin
      wdog_cnt_d = wdog_cnt_q + WdogW'(1);
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign mem_rd            = (state_q == StFetchOp) || (state_q == StFetchLo) ||
                             (state_q == StFetchHi);
  assign mem_addr          = pc_q;
  assign pc                = pc_q;
  assign instruction       = instr_q;
  assign operand           = operand_q;
  assign instruction_ready = (state_q == StExec);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed programs from the
// requirements followed by randomized instructions, wait states, jumps and halts,
// all compared against an instruction-level model of memory and pc.
module tb_fetch_sequencer;

  localparam int unsigned RW   = 8;
  localparam int unsigned AW   = 16;
  localparam int unsigned WDOG = 4;
  localparam logic [15:0] RST_PC = 16'h0200;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack;
  logic [RW-1:0] mem_data;
  logic [AW-1:0] pc;
  logic [RW-1:0] instruction;
  logic [AW-1:0] operand;
  logic          instruction_ready;
  logic          instruction_done;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic          halt;
  logic          timeout;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_pc;
  logic        exp_timeout;
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer #(
    .REG_WIDTH  (RW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (RST_PC),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_addr         (mem_addr),
    .mem_rd           (mem_rd),
    .mem_ack          (mem_ack),
    .mem_data         (mem_data),
    .pc               (pc),
    .instruction      (instruction),
    .operand          (operand),
    .instruction_ready(instruction_ready),
    .instruction_done (instruction_done),
    .jump_valid       (jump_valid),
    .jump_addr        (jump_addr),
    .halt             (halt),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  // Zero-latency memory: data follows the address, validity comes from mem_ack.
  assign mem_data = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Operand-byte count straight from the opcode rules.
  function automatic int ref_len(input logic [7:0] op);
    int a, b, c;
    a = int'(op) / 32;
    b = (int'(op) / 4) % 8;
    c = int'(op) % 4;
    if (b == 3 || b == 7) return 2;
    if (c == 1) return (b == 6) ? 2 : 1;
    if (b == 2 || b == 6) return 0;
    if (b == 0) begin
      if (a >= 4) return 1;
      if (op == 8'h20) return 2;
      return 0;
    end
    return 1;
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_rd", 32'(mem_rd), 0);
    check_eq("rst_ready", 32'(instruction_ready), 0);
    check_eq("rst_pc", 32'(pc), 32'(RST_PC));
    check_eq("rst_addr", 32'(mem_addr), 32'(RST_PC));
    check_eq("rst_instr", 32'(instruction), 0);
    check_eq("rst_operand", 32'(operand), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
  endtask

  // Entered at a negedge with the DUT expected in FETCH_OP. wait_mode < 0 picks
  // random 0..3 wait cycles per byte.
  task automatic run_instr(input int wait_mode, input bit jv, input logic [15:0] ja,
                           input bit hlt, input int hold);
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [15:0] a;
    int n, w;
    op   = mem[exp_pc];
    n    = ref_len(op);
    opnd = 16'h0000;
    if (n >= 1) opnd[7:0]  = mem[exp_pc + 16'd1];
    if (n == 2) opnd[15:8] = mem[exp_pc + 16'd2];
    for (int b = 0; b <= n; b++) begin
      a = exp_pc + 16'(b);
      w = (wait_mode < 0) ? int'($urandom_range(3, 0)) : wait_mode;
      for (int k = 0; k <= w; k++) begin
        check_eq("fetch_rd", 32'(mem_rd), 1);
        check_eq("fetch_addr", 32'(mem_addr), 32'(a));
        check_eq("fetch_pc", 32'(pc), 32'(a));
        check_eq("fetch_ready_low", 32'(instruction_ready), 0);
        mem_ack          = (k == w);
        halt             = 1'($urandom_range(1, 0));
        instruction_done = 1'($urandom_range(1, 0));
        jump_valid       = 1'($urandom_range(1, 0));
        jump_addr        = 16'($urandom);
        @(negedge clk);
      end
    end
    exp_pc = exp_pc + 16'(n + 1);
    for (int k = 0; k <= hold; k++) begin
      check_eq("exec_ready", 32'(instruction_ready), 1);
      check_eq("exec_rd", 32'(mem_rd), 0);
      check_eq("exec_instr", 32'(instruction), 32'(op));
      check_eq("exec_operand", 32'(operand), 32'(opnd));
      check_eq("exec_pc", 32'(pc), 32'(exp_pc));
      check_eq("exec_timeout", 32'(timeout), 32'(exp_timeout));
      if (k == hold) begin
        instruction_done = 1'b1;
        jump_valid       = jv;
        jump_addr        = ja;
        halt             = hlt;
        mem_ack          = 1'($urandom_range(1, 0));
      end else begin
        instruction_done = 1'b0;
        jump_valid       = 1'($urandom_range(1, 0));
        jump_addr        = 16'($urandom);
        halt             = 1'($urandom_range(1, 0));
        mem_ack          = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
    end
    instruction_done = 1'b0;
    jump_valid       = 1'b0;
    mem_ack          = 1'b0;
    if (jv) exp_pc = ja;
    if (hlt) begin
      w = int'($urandom_range(3, 1));
      for (int k = 0; k < w; k++) begin
        check_eq("halt_rd", 32'(mem_rd), 0);
        check_eq("halt_ready", 32'(instruction_ready), 0);
        check_eq("halt_pc", 32'(pc), 32'(exp_pc));
        @(negedge clk);
      end
      halt = 1'b0;
      check_eq("halt_release_rd", 32'(mem_rd), 0);
      @(negedge clk);
    end
    halt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h05;
    mem[16'h0300] = 8'h8D; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
    mem[16'h0303] = 8'hE8;
    mem[16'h0304] = 8'h20; mem[16'h0305] = 8'h78; mem[16'h0306] = 8'h56;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;

    reset_n          = 1'b0;
    mem_ack          = 1'b0;
    instruction_done = 1'b0;
    jump_valid       = 1'b0;
    jump_addr        = '0;
    halt             = 1'b0;
    exp_timeout      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Release reset: IDLE for this cycle, FETCH_OP after the first edge.
    reset_n = 1'b1;
    check_eq("idle_rd", 32'(mem_rd), 0);
    @(negedge clk);
    exp_pc = RST_PC;

    run_instr(0, 1'b1, 16'h0300, 1'b0, 0);   // A9 05 at 0200
    run_instr(3, 1'b0, 16'h0000, 1'b0, 1);   // 8D 34 12, three waits per byte
    run_instr(0, 1'b0, 16'h0000, 1'b0, 0);   // E8, no operands
    run_instr(-1, 1'b1, 16'hFFFF, 1'b0, 2);  // 20 78 56
    run_instr(0, 1'b1, 16'hC000, 1'b1, 0);   // A9 at FFFF wraps to 0000
    check_eq("resume_addr", 32'(mem_addr), 32'hC000);

    for (int i = 0; i < 60; i++) begin
      run_instr(-1, ($urandom_range(4, 0) == 0), 16'($urandom),
                ($urandom_range(4, 0) == 0), int'($urandom_range(2, 0)));
    end

`ifdef FETCH_WATCHDOG_EN
    // Withhold done on a zero-operand opcode until the watchdog fires.
    mem[exp_pc] = 8'hE8;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    exp_pc  = exp_pc + 16'd1;
    for (int k = 0; k < int'(WDOG); k++) begin
      check_eq("wdog_ready", 32'(instruction_ready), 1);
      check_eq("wdog_timeout_low", 32'(timeout), 0);
      @(negedge clk);
    end
    check_eq("wdog_timeout", 32'(timeout), 1);
    check_eq("wdog_ready_drop", 32'(instruction_ready), 0);
    check_eq("wdog_refetch_rd", 32'(mem_rd), 1);
    check_eq("wdog_refetch_addr", 32'(mem_addr), 32'(exp_pc));
    exp_timeout = 1'b1;
    run_instr(-1, 1'b0, 16'h0000, 1'b0, 1);
`else
    check_eq("timeout_tied", 32'(timeout), 0);
`endif

    // Asynchronous reset in the middle of a fetch.
    mem_ack = 1'b0;
    check_eq("pre_reset_rd", 32'(mem_rd), 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    reset_n     = 1'b1;
    exp_pc      = RST_PC;
    exp_timeout = 1'b0;
    @(negedge clk);
    run_instr(-1, 1'b0, 16'h0000, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always ends even if the stimulus stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
